// File: rtl/div_pkg.sv
// Shared types and defaults for the divide-by-N strobe checker.
package div_pkg;

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} chk_state_t;

  localparam int unsigned DIV_DEFAULT        = 3;
  localparam int unsigned LOCK_COUNT_DEFAULT = 4;

endpackage

// File: rtl/div3_sm_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != W'(MAX))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/div3_sm_checker.sv
// Checks that a divided strobe arrives every DIV enable samples; tracks lock and counts errors.
module div3_sm_checker
  import div_pkg::*;
#(
  parameter int unsigned DIV        = DIV_DEFAULT,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEFAULT,
  parameter int unsigned CW         = $clog2(DIV + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          strobe,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] phase,
  output logic [7:0]    err_count
);

  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);

  chk_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [GW-1:0] good;
  logic          good_clr_c, good_inc_c, err_c;
  logic          period_end_c;

  // A sample at cnt == DIV-1 completes a full period.
  assign period_end_c = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= HUNT;
      cnt    <= '0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      locked <= (state_nxt == LOCKED);
      err    <= err_c;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    good_clr_c = 1'b0;
    good_inc_c = 1'b0;
    err_c      = 1'b0;
    if (enable) begin
      case (state)
        HUNT: begin
          cnt_nxt = '0;
          if (strobe) begin
            state_nxt  = TRACK;
            good_clr_c = 1'b1;
          end
        end
        TRACK, LOCKED: begin
          if (strobe) begin
            cnt_nxt = '0;
            if (period_end_c) begin
              good_inc_c = 1'b1;
              if ((state == TRACK) && (good == GW'(LOCK_COUNT - 1))) begin
                state_nxt = LOCKED;
              end
            end else begin
              // Early hit: treat it as a new reference edge.
              err_c      = 1'b1;
              state_nxt  = TRACK;
              good_clr_c = 1'b1;
            end
          end else if (period_end_c) begin
            err_c      = 1'b1;
            state_nxt  = HUNT;
            cnt_nxt    = '0;
            good_clr_c = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = HUNT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign phase = cnt;

  sat_counter #(.W(GW), .MAX(LOCK_COUNT)) u_good (
    .clk   (clk),
    .reset (reset),
    .clr   (good_clr_c),
    .inc   (good_inc_c),
    .count (good)
  );

  sat_counter #(.W(8), .MAX(255)) u_err_count (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (err_c),
    .count (err_count)
  );

endmodule

// File: tb/tb_div3_sm_checker.sv
// Directed self-checking bench for div3_sm_checker at DIV=3, LOCK_COUNT=4.
module tb_div3_sm_checker;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       strobe;
  logic       locked;
  logic       err;
  logic [1:0] phase;
  logic [7:0] err_count;

  int n_assert = 0;
  int n_fail   = 0;

  div3_sm_checker dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .strobe    (strobe),
    .locked    (locked),
    .err       (err),
    .phase     (phase),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then settle just after the rising edge.
  task automatic smp(input logic en, input logic s);
    enable = en;
    strobe = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic l, input logic e,
                         input logic [1:0] p, input logic [7:0] ec);
    chk({tag, ".locked"}, 32'(locked), 32'(l));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".phase"}, 32'(phase), 32'(p));
    chk({tag, ".err_count"}, 32'(err_count), 32'(ec));
  endtask

  // Clean 1,0,0 stream from HUNT: lock on the 13th sample.
  task automatic lock_run(input string tag, input logic [7:0] ec);
    for (int i = 1; i <= 13; i++) begin
      smp(1'b1, (i % 3) == 1);
      chk_all(tag, i == 13, 1'b0, 2'((i - 1) % 3), ec);
    end
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 1'b0, 2'd0, 8'd0);
    reset = 1'b1;

    // HUNT ignores non-hits.
    smp(1'b1, 1'b0);
    chk_all("hunt_idle", 1'b0, 1'b0, 2'd0, 8'd0);

    lock_run("clean", 8'd0);
    smp(1'b1, 1'b0); chk_all("clean_p1", 1'b1, 1'b0, 2'd1, 8'd0);
    smp(1'b1, 1'b0); chk_all("clean_p2", 1'b1, 1'b0, 2'd2, 8'd0);

    // Enable gap with toggling strobe: everything holds.
    for (int i = 0; i < 5; i++) begin
      smp(1'b0, i[0]);
      chk_all("gap", 1'b1, 1'b0, 2'd2, 8'd0);
    end

    // Early strobe while locked: 1,0,1.
    smp(1'b1, 1'b1); chk_all("early_hit", 1'b1, 1'b0, 2'd0, 8'd0);
    smp(1'b1, 1'b0); chk_all("early_p1", 1'b1, 1'b0, 2'd1, 8'd0);
    smp(1'b1, 1'b1); chk_all("early_err", 1'b0, 1'b1, 2'd0, 8'd1);
    for (int j = 1; j <= 12; j++) begin
      smp(1'b1, (j % 3) == 0);
      chk_all("relock", j == 12, 1'b0, 2'(j % 3), 8'd1);
    end

    // Missing strobe while locked: 1,0,0,0.
    smp(1'b1, 1'b0); chk_all("miss_p1", 1'b1, 1'b0, 2'd1, 8'd1);
    smp(1'b1, 1'b0); chk_all("miss_p2", 1'b1, 1'b0, 2'd2, 8'd1);
    smp(1'b1, 1'b0); chk_all("miss_err", 1'b0, 1'b1, 2'd0, 8'd2);
    smp(1'b1, 1'b0); chk_all("miss_hunt", 1'b0, 1'b0, 2'd0, 8'd2);

    lock_run("lock2", 8'd2);
    smp(1'b1, 1'b0);
    smp(1'b1, 1'b0); chk_all("pre_rst", 1'b1, 1'b0, 2'd2, 8'd2);

    // Asynchronous reset mid-period.
    #2 reset = 1'b0;
    #1 chk_all("async_rst", 1'b0, 1'b0, 2'd0, 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    lock_run("post_rst", 8'd0);

    // Back-to-back early hits saturate err_count.
    for (int k = 1; k <= 300; k++) begin
      smp(1'b1, 1'b1);
      chk({"sat.err"}, 32'(err), 32'd1);
      chk({"sat.err_count"}, 32'(err_count), (k < 255) ? 32'(k) : 32'd255);
    end
    chk("sat.locked", 32'(locked), 32'd0);
    smp(1'b0, 1'b1); chk_all("sat_gap", 1'b0, 1'b0, 2'd0, 8'd255);
    smp(1'b1, 1'b1); chk_all("sat_hold", 1'b0, 1'b1, 2'd0, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
